instr_phase_ctrl: RTL and testbench

Instruction-side partner of the step sequencer: consumes its CK_*/STB_* phase strobes and returns the two signals the sequencer needs, SEQTYPE (addressing-mode path select) and DONE (early end of instruction). It latches the fetched word into the instruction register and decodes the addressing mode. It tracks progress through the fetch/auto-index/indirect/execute phases, counts execute phases per opcode, and flags strobe-order protocol violations.

---
 rtl/pdp8_pkg.sv | 49 ++++
 rtl/instr_mode_decode.sv | 24 ++
 rtl/instr_phase_ctrl.sv | 166 ++++++++++++++++
 tb/tb_instr_phase_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_pkg.sv
// Shared PDP-8 instruction-side definitions: opcodes, sequencer path encodings,
// phase-controller states and the execute-phase count per opcode.
package pdp8_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_TAD = 3'd1;
  localparam logic [2:0] OP_ISZ = 3'd2;
  localparam logic [2:0] OP_DCA = 3'd3;
  localparam logic [2:0] OP_JMS = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_IOT = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;

  // {isPPIND, isIND}; 2'b10 cannot occur because isPPIND implies isIND
  localparam logic [1:0] SEQ_DIRECT = 2'b00;
  localparam logic [1:0] SEQ_IND    = 2'b01;
  localparam logic [1:0] SEQ_PPIND  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCHED,
    ST_AUTO1,
    ST_AUTO2,
    ST_INDIR,
    ST_EXEC
  } state_e;

  function automatic logic [2:0] nphase_of(input logic [2:0] op, input logic grp2);
    logic [2:0] n;
    case (op)
      OP_ISZ, OP_IOT: n = 3'd3;
      OP_JMP:         n = 3'd1;
      OP_OPR:         n = grp2 ? 3'd3 : 3'd4;
      default:        n = 3'd2;
    endcase
    return n;
  endfunction

  // Highest-numbered execute strobe present, 0 when none
  function automatic logic [2:0] exec_strobe_num(input logic [5:0] s);
    logic [2:0] k;
    k = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (s[i]) k = 3'(i + 1);
    end
    return k;
  endfunction

endpackage

// File: rtl/instr_mode_decode.sv
// Combinational addressing-mode and execute-length decode of one instruction word.
module instr_mode_decode
  import pdp8_pkg::*;
#(
  parameter logic [6:0] AUTO_LO = 7'o010,
  parameter logic [6:0] AUTO_HI = 7'o017
) (
  input  logic [11:0] word_i,
  output logic        is_ppind_o,
  output logic        is_ind_o,
  output logic [2:0]  nphase_o
);

  logic [2:0] op;
  logic [6:0] off;

  assign op  = word_i[11:9];
  assign off = word_i[6:0];

  assign is_ind_o   = (op < OP_IOT) & word_i[8];
  assign is_ppind_o = is_ind_o & ~word_i[7] & (off >= AUTO_LO) & (off <= AUTO_HI);
  assign nphase_o   = nphase_of(op, word_i[8]);

endmodule

// File: rtl/instr_phase_ctrl.sv
// Instruction-side phase controller: latches IR, returns SEQTYPE/DONE to the step
// sequencer, tracks fetch/auto/indirect/execute progress and flags strobe-order errors.
module instr_phase_ctrl
  import pdp8_pkg::*;
#(
  parameter logic [6:0] AUTO_LO = 7'o010,
  parameter logic [6:0] AUTO_HI = 7'o017
) (
  input  logic        SYSCLK,
  input  logic        RESET,
  input  logic [11:0] MEMDATA,
  input  logic        CK_FETCH,
  input  logic        CK_AUTO1,
  input  logic        CK_AUTO2,
  input  logic        CK_IND,
  input  logic        STB_FETCH,
  input  logic        STB_AUTO1,
  input  logic        STB_AUTO2,
  input  logic        STB_IND,
  input  logic        STB_1,
  input  logic        STB_2,
  input  logic        STB_3,
  input  logic        STB_4,
  input  logic        STB_5,
  input  logic        STB_6,
  output logic [11:0] IR,
  output logic [1:0]  SEQTYPE,
  output logic        DONE,
  output logic [2:0]  PHASE,
  output logic        AUTOINC,
  output logic        ERR
);

  state_e      state_q, state_d;
  logic [2:0]  exec_n_q, exec_n_d;
  logic [11:0] ir_q;
  logic [2:0]  nphase_q;
  logic        err_q;

  logic [9:0]  stb;
  logic [5:0]  stb_x;
  logic [7:0]  stb_k;
  logic [2:0]  stb_num;
  logic        mem_ppind, mem_ind, ir_ppind, ir_ind;
  logic [2:0]  mem_nph, unused_ir_nph;
  logic [1:0]  mem_seq, ir_seq;
  logic        exec_win, multi, ord_bad, range_bad, viol;
  logic        done;
  logic [2:0]  phase;
  logic        autoinc;

  assign stb     = {STB_6, STB_5, STB_4, STB_3, STB_2, STB_1,
                    STB_IND, STB_AUTO2, STB_AUTO1, STB_FETCH};
  assign stb_x   = stb[9:4];
  assign stb_k   = {1'b0, stb_x, 1'b0};
  assign stb_num = exec_strobe_num(stb_x);

  instr_mode_decode #(.AUTO_LO(AUTO_LO), .AUTO_HI(AUTO_HI)) u_dec_mem (
    .word_i     (MEMDATA),
    .is_ppind_o (mem_ppind),
    .is_ind_o   (mem_ind),
    .nphase_o   (mem_nph)
  );

  instr_mode_decode #(.AUTO_LO(AUTO_LO), .AUTO_HI(AUTO_HI)) u_dec_ir (
    .word_i     (ir_q),
    .is_ppind_o (ir_ppind),
    .is_ind_o   (ir_ind),
    .nphase_o   (unused_ir_nph)
  );

  assign mem_seq  = {mem_ppind, mem_ind};
  assign ir_seq   = {ir_ppind, ir_ind};
  assign exec_win = ~(CK_FETCH | CK_AUTO1 | CK_AUTO2 | CK_IND);

  // Protocol checking: order is judged on the single strobe present
  assign multi     = ($countones(stb) > 1);
  assign range_bad = (stb_num > nphase_q);

  always_comb begin
    ord_bad = 1'b0;
    if (STB_FETCH)
      ord_bad = 1'b0;
    else if (STB_AUTO1)
      ord_bad = !(state_q == ST_FETCHED && ir_seq == SEQ_PPIND);
    else if (STB_AUTO2)
      ord_bad = (state_q != ST_AUTO1);
    else if (STB_IND)
      ord_bad = !(state_q == ST_AUTO2 || (state_q == ST_FETCHED && ir_seq == SEQ_IND));
    else if (stb_num == 3'd1)
      ord_bad = !(state_q == ST_INDIR || (state_q == ST_FETCHED && ir_seq == SEQ_DIRECT));
    else if (stb_num != 3'd0)
      ord_bad = !(state_q == ST_EXEC && exec_n_q == stb_num - 3'd1);
  end

  assign viol = multi | ord_bad | range_bad;

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      exec_n_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      exec_n_q <= exec_n_d;
    end
  end

  // Errors do not block progress: the strobe still moves the state to its phase
  always_comb begin
    state_d  = state_q;
    exec_n_d = exec_n_q;
    if (STB_FETCH) begin
      state_d  = ST_FETCHED;
      exec_n_d = 3'd0;
    end else if (done) begin
      state_d  = ST_IDLE;
      exec_n_d = 3'd0;
    end else if (STB_AUTO1) begin
      state_d = ST_AUTO1;
    end else if (STB_AUTO2) begin
      state_d = ST_AUTO2;
    end else if (STB_IND) begin
      state_d = ST_INDIR;
    end else if (stb_num != 3'd0) begin
      state_d  = ST_EXEC;
      exec_n_d = stb_num;
    end
  end

  always_comb begin
    SEQTYPE = STB_FETCH ? mem_seq : ir_seq;
    done    = ~RESET & stb_k[nphase_q];
    autoinc = ir_ppind & ((CK_AUTO1 & (state_q == ST_FETCHED)) |
                          (CK_AUTO2 & (state_q == ST_AUTO1)));
    phase   = 3'd0;
    if (exec_win) begin
      if (state_q == ST_INDIR)
        phase = 3'd1;
      else if (state_q == ST_FETCHED && ir_seq == SEQ_DIRECT)
        phase = 3'd1;
      else if (state_q == ST_EXEC && exec_n_q < nphase_q)
        phase = exec_n_q + 3'd1;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      ir_q     <= 12'd0;
      nphase_q <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      if (STB_FETCH) begin
        ir_q     <= MEMDATA;
        nphase_q <= mem_nph;
      end
      if (viol) err_q <= 1'b1;
    end
  end

  assign IR      = ir_q;
  assign DONE    = done;
  assign PHASE   = phase;
  assign AUTOINC = autoinc;
  assign ERR     = err_q;

endmodule

// File: tb/tb_instr_phase_ctrl.sv
// Scoreboard bench for instr_phase_ctrl: expected DONE events queued at fetch and
// retired when DONE appears; other outputs checked directly against expectations.
module tb_instr_phase_ctrl;

  logic        SYSCLK = 1'b0;
  logic        RESET;
  logic [11:0] MEMDATA;
  logic [9:0]  stb;
  logic [3:0]  ck;
  logic [11:0] IR;
  logic [1:0]  SEQTYPE;
  logic        DONE;
  logic [2:0]  PHASE;
  logic        AUTOINC;
  logic        ERR;

  typedef struct {
    int          k;
    logic [11:0] ir;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  instr_phase_ctrl dut (
    .SYSCLK    (SYSCLK),
    .RESET     (RESET),
    .MEMDATA   (MEMDATA),
    .CK_FETCH  (ck[0]),
    .CK_AUTO1  (ck[1]),
    .CK_AUTO2  (ck[2]),
    .CK_IND    (ck[3]),
    .STB_FETCH (stb[0]),
    .STB_AUTO1 (stb[1]),
    .STB_AUTO2 (stb[2]),
    .STB_IND   (stb[3]),
    .STB_1     (stb[4]),
    .STB_2     (stb[5]),
    .STB_3     (stb[6]),
    .STB_4     (stb[7]),
    .STB_5     (stb[8]),
    .STB_6     (stb[9]),
    .IR        (IR),
    .SEQTYPE   (SEQTYPE),
    .DONE      (DONE),
    .PHASE     (PHASE),
    .AUTOINC   (AUTOINC),
    .ERR       (ERR)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // DONE retires the oldest expected instruction completion
  always @(negedge SYSCLK) begin
    int   k;
    exp_t e;
    if (DONE === 1'b1) begin
      k = 0;
      for (int i = 0; i < 6; i++) if (stb[4 + i]) k = i + 1;
      if (sb_q.size() == 0) begin
        chk("done_unexpected", DONE, 0);
      end else begin
        e = sb_q.pop_front();
        chk("done_k", k, e.k);
        chk("done_ir", IR, e.ir);
      end
    end
  end

  task automatic step();
    @(posedge SYSCLK);
    #1;
    stb = '0;
    ck  = '0;
  endtask

  task automatic strobe_cycle(input logic [9:0] s, input logic [3:0] c);
    stb = s;
    ck  = c;
    @(negedge SYSCLK);
    step();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    stb   = '0;
    ck    = '0;
    @(posedge SYSCLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic fetch(input logic [11:0] w, input logic [1:0] seq);
    MEMDATA = w;
    stb     = 10'b0000000001;
    ck      = 4'b0001;
    @(negedge SYSCLK);
    chk("seqtype_at_fetch", SEQTYPE, seq);
    step();
    @(negedge SYSCLK);
    chk("ir_after_fetch", IR, w);
    step();
  endtask

  task automatic run_instr(input logic [11:0] w, input logic [1:0] seq,
                           input int nph, input logic exp_err);
    sb_q.push_back('{k: nph, ir: w});
    fetch(w, seq);
    if (seq == 2'b11) begin
      ck = 4'b0010;
      @(negedge SYSCLK);
      chk("autoinc_auto1", AUTOINC, 1);
      step();
      strobe_cycle(10'b0000000010, 4'b0010);
      ck = 4'b0100;
      @(negedge SYSCLK);
      chk("autoinc_auto2", AUTOINC, 1);
      step();
      strobe_cycle(10'b0000000100, 4'b0100);
      strobe_cycle(10'b0000001000, 4'b1000);
    end else if (seq == 2'b01) begin
      strobe_cycle(10'b0000001000, 4'b1000);
    end
    for (int n = 1; n <= nph; n++) begin
      stb = 10'(1) << (3 + n);
      @(negedge SYSCLK);
      chk("phase_exec", PHASE, n);
      step();
    end
    @(negedge SYSCLK);
    chk("phase_idle", PHASE, 0);
    chk("err_after_instr", ERR, exp_err);
    chk("sb_drained", sb_q.size(), 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    RESET   = 1'b1;
    stb     = '0;
    ck      = '0;
    MEMDATA = '0;
    repeat (2) @(posedge SYSCLK);
    #1;
    RESET = 1'b0;
    @(negedge SYSCLK);
    chk("rst_ir", IR, 0);
    chk("rst_seqtype", SEQTYPE, 0);
    chk("rst_phase", PHASE, 0);
    chk("rst_done", DONE, 0);
    chk("rst_autoinc", AUTOINC, 0);
    chk("rst_err", ERR, 0);
    step();

    run_instr(12'o1100, 2'b00, 2, 1'b0);
    run_instr(12'o1500, 2'b01, 2, 1'b0);
    run_instr(12'o1410, 2'b11, 2, 1'b0);
    run_instr(12'o1420, 2'b01, 2, 1'b0);
    run_instr(12'o5200, 2'b00, 1, 1'b0);
    run_instr(12'o7200, 2'b00, 4, 1'b0);
    run_instr(12'o7402, 2'b00, 3, 1'b0);
    run_instr(12'o2050, 2'b00, 3, 1'b0);

    // STB_2 with no STB_1; DONE still follows the strobe
    sb_q.push_back('{k: 2, ir: 12'o1100});
    fetch(12'o1100, 2'b00);
    stb = 10'b0000100000;
    @(negedge SYSCLK);
    chk("err_not_yet", ERR, 0);
    step();
    @(negedge SYSCLK);
    chk("err_skip_stb1", ERR, 1);
    step();
    run_instr(12'o1100, 2'b00, 2, 1'b1);
    do_reset();
    @(negedge SYSCLK);
    chk("err_cleared", ERR, 0);
    step();

    // STB_AUTO1 after a direct fetch
    fetch(12'o1100, 2'b00);
    strobe_cycle(10'b0000000010, 4'b0010);
    @(negedge SYSCLK);
    chk("err_auto1_direct", ERR, 1);
    step();
    do_reset();

    // STB_1 and STB_2 together
    sb_q.push_back('{k: 2, ir: 12'o1100});
    fetch(12'o1100, 2'b00);
    strobe_cycle(10'b0000110000, 4'b0000);
    @(negedge SYSCLK);
    chk("err_multi", ERR, 1);
    chk("sb_drained_multi", sb_q.size(), 0);
    step();
    do_reset();

    // RESET during EXEC(2) of ISZ, with STB_3 in the same cycle
    fetch(12'o2050, 2'b00);
    strobe_cycle(10'b0000010000, 4'b0000);
    strobe_cycle(10'b0000100000, 4'b0000);
    RESET = 1'b1;
    stb   = 10'b0001000000;
    @(negedge SYSCLK);
    chk("done_gated_by_reset", DONE, 0);
    step();
    RESET = 1'b0;
    @(negedge SYSCLK);
    chk("midrst_ir", IR, 0);
    chk("midrst_phase", PHASE, 0);
    chk("midrst_done", DONE, 0);
    chk("midrst_seqtype", SEQTYPE, 0);
    chk("midrst_err", ERR, 0);
    step();
    run_instr(12'o1100, 2'b00, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
